// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the digit scan controller: FSM state encodings
// and the default slot timing used by the top-level display block.
package digit_scan_ctrl_pkg;

  // Scan FSM encodings (ST_BLANK is only reachable with DIGIT_SCAN_BLANKING_EN).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Default slot timing for the display block.
  localparam int unsigned DEF_CLK_DIV      = 50000;
  localparam int unsigned DEF_BLANK_CYCLES = 4;

endpackage

// File: rtl/digit_scan_ctrl_prescaler.sv
// Slot prescaler for the digit scan controller: modulo-CLK_DIV counter with
// a synchronous clear and a terminal-count flag on the last cycle of a slot.
module scan_prescaler #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;

  assign tc    = (count_q == CNT_W'(CLK_DIV - 1));
  assign count = count_q;

  // Count 0..CLK_DIV-1, wrap at terminal count, hold at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr || tc) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 7-segment digit scan controller. Drives the digit-mux
// select and active-low anode enables, one slot of CLK_DIV cycles per digit.
// Optional ghost blanking at the start of each slot: DIGIT_SCAN_BLANKING_EN.
// All outputs are registered; blank always equals &an_n.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS   = 4,
  parameter  int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter  int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int unsigned SEL_W        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  blank,
  output logic                  frame_tick,
  output scan_state_e           dbg_state_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  scan_state_e           state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                  blank_q;
  logic                  frame_tick_q;

  logic [CNT_W-1:0]      scan_cnt;
  logic                  slot_end;
  logic                  scan_clr;
  logic                  sel_wrap;
  logic [SEL_W-1:0]      sel_adv;

  // Active-low one-cold anode pattern for digit s.
  function automatic logic [NUM_DIGITS-1:0] anode_of(input logic [SEL_W-1:0] s);
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return ~(one << s);
  endfunction

  // Prescaler is held at zero while idle or disabled, so a restart begins a fresh slot.
  assign scan_clr = ~en | (state_q == ST_IDLE);

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_clr),
    .count (scan_cnt),
    .tc    (slot_end)
  );

  assign sel_wrap = (sel_q == SEL_W'(NUM_DIGITS - 1));
  assign sel_adv  = sel_wrap ? '0 : sel_q + SEL_W'(1);

`ifdef DIGIT_SCAN_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`else
  // Without blanking the blank length and the in-slot count are not needed.
  logic unused_cfg;
  assign unused_cfg = (BLANK_CYCLES == 0) | (|scan_cnt);
`endif

  // Scan FSM with registered select, anode, blank and frame-tick outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      an_n_q       <= '1;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else if (!en) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      an_n_q       <= '1;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sel_q <= '0;
`ifdef DIGIT_SCAN_BLANKING_EN
          state_q <= ST_BLANK;
          an_n_q  <= '1;
          blank_q <= 1'b1;
`else
          state_q <= ST_ON;
          an_n_q  <= anode_of('0);
          blank_q <= 1'b0;
`endif
        end
`ifdef DIGIT_SCAN_BLANKING_EN
        ST_BLANK: begin
          if (scan_cnt == BLANK_LAST) begin
            state_q <= ST_ON;
            an_n_q  <= anode_of(sel_q);
            blank_q <= 1'b0;
          end
        end
`endif
        ST_ON: begin
          if (slot_end) begin
            sel_q        <= sel_adv;
            frame_tick_q <= sel_wrap;
`ifdef DIGIT_SCAN_BLANKING_EN
            state_q <= ST_BLANK;
            an_n_q  <= '1;
            blank_q <= 1'b1;
`else
            an_n_q  <= anode_of(sel_adv);
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= '0;
          an_n_q  <= '1;
          blank_q <= 1'b1;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign an_n        = an_n_q;
  assign blank       = blank_q;
  assign frame_tick  = frame_tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with NUM_DIGITS=4, CLK_DIV=8,
// BLANK_CYCLES=2. Expectations follow the build's DIGIT_SCAN_BLANKING_EN.
module tb_digit_scan_ctrl;
  import digit_scan_ctrl_pkg::*;

`ifdef DIGIT_SCAN_BLANKING_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [3:0]  an_n;
  logic        blank;
  logic        frame_tick;
  scan_state_e dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  // Cycles at which frame_tick is expected, in order.
  logic [31:0] exp_q[$];

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] an_n;
    logic       blank;
    logic       tick;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  digit_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sel         (sel),
    .an_n        (an_n),
    .blank       (blank),
    .frame_tick  (frame_tick),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One rising edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input int c, input logic [1:0] s,
                         input logic [3:0] a, input logic b, input logic t);
    tbl[i].cyc   = c;
    tbl[i].sel   = s;
    tbl[i].an_n  = a;
    tbl[i].blank = b;
    tbl[i].tick  = t;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] s,
                            input logic [3:0] a, input logic b, input logic t);
    check({tag, "_sel"},   32'(sel),        32'(s));
    check({tag, "_an_n"},  32'(an_n),       32'(a));
    check({tag, "_blank"}, 32'(blank),      32'(b));
    check({tag, "_tick"},  32'(frame_tick), 32'(t));
  endtask

  initial begin
    int ti;

    // Hand-computed per-cycle expectations after reset release.
    set_vec(0,  1,  2'd0, BLK ? 4'b1111 : 4'b1110, BLK,  1'b0);
    set_vec(1,  2,  2'd0, BLK ? 4'b1111 : 4'b1110, BLK,  1'b0);
    set_vec(2,  3,  2'd0, 4'b1110,                 1'b0, 1'b0);
    set_vec(3,  8,  2'd0, 4'b1110,                 1'b0, 1'b0);
    set_vec(4,  9,  2'd1, BLK ? 4'b1111 : 4'b1101, BLK,  1'b0);
    set_vec(5,  11, 2'd1, 4'b1101,                 1'b0, 1'b0);
    set_vec(6,  17, 2'd2, BLK ? 4'b1111 : 4'b1011, BLK,  1'b0);
    set_vec(7,  19, 2'd2, 4'b1011,                 1'b0, 1'b0);
    set_vec(8,  32, 2'd3, 4'b0111,                 1'b0, 1'b0);
    set_vec(9,  33, 2'd0, BLK ? 4'b1111 : 4'b1110, BLK,  1'b1);
    set_vec(10, 34, 2'd0, BLK ? 4'b1111 : 4'b1110, BLK,  1'b0);
    set_vec(11, 35, 2'd0, 4'b1110,                 1'b0, 1'b0);
    set_vec(12, 64, 2'd3, 4'b0111,                 1'b0, 1'b0);
    set_vec(13, 65, 2'd0, BLK ? 4'b1111 : 4'b1110, BLK,  1'b1);
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd65);

    // Reset with en held high.
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("reset", 2'd0, 4'b1111, 1'b1, 1'b0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cyc   = 0;

    // Two full frames: table vectors, invariants, frame_tick scoreboard.
    ti = 0;
    for (int c = 1; c <= 65; c++) begin
      step();
      check("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
      check("blank_inv", 32'(blank), 32'(&an_n));
      if (frame_tick) begin
        if (exp_q.size() == 0) check("tick_unexpected", 32'(cyc), 32'd0);
        else check("tick_cycle", 32'(cyc), exp_q.pop_front());
      end
      if (ti < NV && tbl[ti].cyc == cyc) begin
        check_outs($sformatf("vec%0d", ti), tbl[ti].sel, tbl[ti].an_n,
                   tbl[ti].blank, tbl[ti].tick);
        ti++;
      end
    end
    check("tick_q_empty", 32'(exp_q.size()), 32'd0);

    // Drop en while digit 2 is lit.
    while (cyc < 84) step();
    check_outs("pre_drop", 2'd2, 4'b1011, 1'b0, 1'b0);
    en = 1'b0;
    step();
    check_outs("drop", 2'd0, 4'b1111, 1'b1, 1'b0);
    check("drop_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check_outs("idle_hold", 2'd0, 4'b1111, 1'b1, 1'b0);

    // Re-raise en: full blank interval before digit 0 lights.
    en = 1'b1;
    step();
    check_outs("restart0", 2'd0, BLK ? 4'b1111 : 4'b1110, BLK, 1'b0);
    step();
    check_outs("restart1", 2'd0, BLK ? 4'b1111 : 4'b1110, BLK, 1'b0);
    step();
    check_outs("restart2", 2'd0, 4'b1110, 1'b0, 1'b0);
    repeat (10) step();
    check_outs("restart12", 2'd1, 4'b1101, 1'b0, 1'b0);

    // Asynchronous reset mid-ON, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd0, 4'b1111, 1'b1, 1'b0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    step();
    check_outs("post_rst1", 2'd0, BLK ? 4'b1111 : 4'b1110, BLK, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
